// File: rtl/lut_sweeper_pkg.sv
// lut_sweeper_pkg: shared FSM encoding and table sizing for the LUT sweeper
package lut_sweeper_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;
  function automatic int rows(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/lut_sweeper_eval.sv
// lut_eval: combinational truth-table lookup
module lut_eval
  import lut_sweeper_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [rows(N_IN)-1:0] lut,
  input  logic [N_IN-1:0]       idx,
  output logic                  q
);
  assign q = lut[idx];
endmodule

// File: rtl/lut_sweeper.sv
// lut_sweeper: sweeps every input vector through a loadable truth table, counting ones
module lut_sweeper
  import lut_sweeper_pkg::*;
#(
  parameter int                     N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0]   RESET_LUT = 8'hE2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lut_load,
  input  logic [rows(N_IN)-1:0] lut_data,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_IN-1:0]       in_vec,
  output logic                  out_bit,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN:0]         ones_count
);
  localparam int CW = N_IN + 1;
  state_t state, state_n;
  logic [rows(N_IN)-1:0] lut;
  logic [N_IN-1:0] nxt_idx;
  logic nxt_bit, idle, go, last;
  // The row register doubles as the sweep index; lookup runs on the row about to be presented.
  lut_eval #(.N_IN(N_IN)) u_eval (.lut(lut), .idx(nxt_idx), .q(nxt_bit));
  always_comb begin
    idle    = state != SWEEP;
    go      = idle && start && !lut_load;
    last    = &in_vec;
    nxt_idx = idle ? '0 : in_vec + 1'b1;
    state_n = go ? SWEEP :
              (!idle && abort) ? IDLE :
              (!idle && last) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lut        <= RESET_LUT;
      in_vec     <= '0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      ones_count <= '0;
    end else begin
      state     <= state_n;
      out_valid <= state_n == SWEEP;
      if (idle && lut_load) lut <= lut_data;
      if (state_n == SWEEP) begin
        in_vec     <= nxt_idx;
        out_bit    <= nxt_bit;
        ones_count <= (go ? '0 : ones_count) + CW'(nxt_bit);
      end
    end
  end
  assign busy = state == SWEEP;
  assign done = state == DONE;
endmodule

// File: tb/tb_lut_sweeper.sv
// tb_lut_sweeper: scoreboard bench over three widths of the LUT sweeper
module tb_lut_sweeper;
  typedef struct {int idx; int b; int ones;} row_t;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  row_t qa[$], qb[$], qc[$];
  row_t ra, rb, rc;
  logic [7:0] ma;
  logic [1:0] mb;
  logic [63:0] mc;
  logic reset;
  logic a_load, a_start, a_abort, a_bit, a_valid, a_busy, a_done;
  logic [7:0] a_data;
  logic [2:0] a_in;
  logic [3:0] a_ones;
  logic b_load, b_start, b_abort, b_bit, b_valid, b_busy, b_done;
  logic [1:0] b_data;
  logic [0:0] b_in;
  logic [1:0] b_ones;
  logic c_load, c_start, c_abort, c_bit, c_valid, c_busy, c_done;
  logic [63:0] c_data;
  logic [5:0] c_in;
  logic [6:0] c_ones;

  lut_sweeper #(.N_IN(3), .RESET_LUT(8'hE2)) dut (
    .clk(clk), .reset(reset), .lut_load(a_load), .lut_data(a_data), .start(a_start),
    .abort(a_abort), .in_vec(a_in), .out_bit(a_bit), .out_valid(a_valid), .busy(a_busy),
    .done(a_done), .ones_count(a_ones));
  lut_sweeper #(.N_IN(1), .RESET_LUT(2'b10)) dut_b (
    .clk(clk), .reset(reset), .lut_load(b_load), .lut_data(b_data), .start(b_start),
    .abort(b_abort), .in_vec(b_in), .out_bit(b_bit), .out_valid(b_valid), .busy(b_busy),
    .done(b_done), .ones_count(b_ones));
  lut_sweeper #(.N_IN(6), .RESET_LUT(64'h0)) dut_c (
    .clk(clk), .reset(reset), .lut_load(c_load), .lut_data(c_data), .start(c_start),
    .abort(c_abort), .in_vec(c_in), .out_bit(c_bit), .out_valid(c_valid), .busy(c_busy),
    .done(c_done), .ones_count(c_ones));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int pop_cnt(input logic [63:0] t, input int upto);
    int s = 0;
    for (int i = 0; i <= upto; i++) s += int'(t[i]);
    return s;
  endfunction

  // A sweep of table t is the rows 0..n-1 in order with a running count of ones.
  function automatic void expect_sweep(input int which, input logic [63:0] t, input int n);
    row_t r;
    for (int i = 0; i < n; i++) begin
      r = '{i, int'(t[i]), pop_cnt(t, i)};
      if (which == 0) qa.push_back(r);
      else if (which == 1) qb.push_back(r);
      else qc.push_back(r);
    end
  endfunction

  task automatic unexpected(input string nm, input int got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got row %0d expected no row", nm, got);
  endtask

  always @(negedge clk) if (a_valid) begin
    if (qa.size() == 0) unexpected("a_extra_row", int'(a_in));
    else begin
      ra = qa.pop_front();
      chk("a_in_vec", 64'(a_in), 64'(ra.idx));
      chk("a_out_bit", 64'(a_bit), 64'(ra.b));
      chk("a_ones", 64'(a_ones), 64'(ra.ones));
      chk("a_busy", 64'(a_busy), 64'd1);
    end
  end
  always @(negedge clk) if (b_valid) begin
    if (qb.size() == 0) unexpected("b_extra_row", int'(b_in));
    else begin
      rb = qb.pop_front();
      chk("b_in_vec", 64'(b_in), 64'(rb.idx));
      chk("b_out_bit", 64'(b_bit), 64'(rb.b));
      chk("b_ones", 64'(b_ones), 64'(rb.ones));
    end
  end
  always @(negedge clk) if (c_valid) begin
    if (qc.size() == 0) unexpected("c_extra_row", int'(c_in));
    else begin
      rc = qc.pop_front();
      chk("c_in_vec", 64'(c_in), 64'(rc.idx));
      chk("c_out_bit", 64'(c_bit), 64'(rc.b));
      chk("c_ones", 64'(c_ones), 64'(rc.ones));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_ld(input logic [7:0] v);
    a_load = 1; a_data = v; ma = v;
    step();
    a_load = 0;
  endtask

  task automatic a_go();
    a_start = 1;
    expect_sweep(0, 64'(ma), 8);
    step();
    a_start = 0;
  endtask

  task automatic a_wait_done(input string nm);
    for (int k = 0; k < 40 && !a_done; k++) step();
    chk({nm, "_done"}, 64'(a_done), 64'd1);
    chk({nm, "_ones"}, 64'(a_ones), 64'(pop_cnt(64'(ma), 7)));
    chk({nm, "_valid_low"}, 64'(a_valid), 64'd0);
    chk({nm, "_busy_low"}, 64'(a_busy), 64'd0);
    chk({nm, "_rows_left"}, 64'(qa.size()), 64'd0);
    chk({nm, "_in_vec_hold"}, 64'(a_in), 64'd7);
  endtask

  task automatic a_wait_row(input int r);
    for (int k = 0; k < 40 && !(a_valid && int'(a_in) == r); k++) step();
    chk("a_row_reached", 64'(a_in), 64'(r));
  endtask

  task automatic a_abort_at(input int r);
    a_wait_row(r);
    a_abort = 1;
    step();
    a_abort = 0;
    qa.delete();
    chk("abort_valid", 64'(a_valid), 64'd0);
    chk("abort_done", 64'(a_done), 64'd0);
    chk("abort_busy", 64'(a_busy), 64'd0);
    chk("abort_ones", 64'(a_ones), 64'(pop_cnt(64'(ma), r)));
  endtask

  initial begin
    reset = 1;
    {a_load, a_start, a_abort, b_load, b_start, b_abort, c_load, c_start, c_abort} = '0;
    a_data = '0; b_data = '0; c_data = '0;
    repeat (2) step();
    chk("rst_in_vec", 64'(a_in), 64'd0);
    chk("rst_out_bit", 64'(a_bit), 64'd0);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_ones", 64'(a_ones), 64'd0);
    reset = 0;
    ma = 8'hE2; mb = 2'b10; mc = '0;
    a_go();
    a_wait_done("default");
    a_abort = 1;
    step();
    a_abort = 0;
    chk("abort_idle_done", 64'(a_done), 64'd1);
    chk("abort_idle_ones", 64'(a_ones), 64'd4);
    a_ld(8'hFF); a_go(); a_wait_done("all_ones");
    a_ld(8'h00); a_go(); a_wait_done("all_zeros");
    a_ld(8'hE2); a_go();
    step(); step();
    a_load = 1; a_data = 8'h00; a_start = 1;
    step();
    a_load = 0; a_start = 0;
    a_wait_done("load_in_sweep");
    a_go();
    a_abort_at(3);
    a_abort = 1; a_start = 1;
    expect_sweep(0, 64'(ma), 8);
    step();
    a_abort = 0; a_start = 0;
    a_wait_done("abort_and_start");
    a_go();
    a_wait_row(5);
    reset = 1;
    step();
    reset = 0;
    qa.delete();
    chk("midrst_in_vec", 64'(a_in), 64'd0);
    chk("midrst_out_bit", 64'(a_bit), 64'd0);
    chk("midrst_valid", 64'(a_valid), 64'd0);
    chk("midrst_busy", 64'(a_busy), 64'd0);
    chk("midrst_done", 64'(a_done), 64'd0);
    chk("midrst_ones", 64'(a_ones), 64'd0);
    ma = 8'hE2;
    a_go();
    a_wait_done("after_reset");
    a_load = 1; a_start = 1; a_data = 8'h5A; ma = 8'h5A;
    step();
    a_load = 0; a_start = 0;
    chk("load_beats_start", 64'(a_busy), 64'd0);
    a_go();
    a_wait_done("loaded_5a");
    repeat (8) begin
      a_ld(8'($urandom));
      a_go();
      if ($urandom_range(0, 1) == 1) a_abort_at(int'($urandom_range(0, 7)));
      else a_wait_done("random");
    end
    b_start = 1;
    expect_sweep(1, 64'(mb), 2);
    step();
    b_start = 0;
    for (int k = 0; k < 20 && !b_done; k++) step();
    chk("n1_done", 64'(b_done), 64'd1);
    chk("n1_ones", 64'(b_ones), 64'd1);
    chk("n1_rows_left", 64'(qb.size()), 64'd0);
    c_load = 1; c_data = '1; mc = '1;
    step();
    c_load = 0;
    c_start = 1;
    expect_sweep(2, mc, 64);
    step();
    c_start = 0;
    for (int k = 0; k < 100 && !c_done; k++) step();
    chk("n6_done", 64'(c_done), 64'd1);
    chk("n6_ones", 64'(c_ones), 64'd64);
    chk("n6_rows_left", 64'(qc.size()), 64'd0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lut_sweeper.md
LUT_SWEEPER -- requirements
Module: lut_sweeper

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, meaning number of function inputs; legal range 1..6.
REQ-002 The block SHALL have parameter RESET_LUT, default 8'hE2 (width 2^N_IN), meaning the truth table loaded at reset; the default encodes s = (~y & z) | (x & y) with index {x,y,z}.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 The block SHALL have port lut_load  input  1  meaning capture lut_data into the truth-table register.
REQ-006 The block SHALL have port lut_data  input  2^N_IN  meaning truth table, bit i = output for input vector i.
REQ-007 The block SHALL have port start  input  1  meaning begin a sweep of all input vectors.
REQ-008 The block SHALL have port abort  input  1  meaning terminate a sweep in progress.
REQ-009 The block SHALL have port in_vec  output  N_IN  meaning input vector currently presented, MSB = first variable.
REQ-010 The block SHALL have port out_bit  output  1  meaning function value for in_vec.
REQ-011 The block SHALL have port out_valid  output  1  meaning in_vec/out_bit form a valid truth-table row this cycle.
REQ-012 The block SHALL have ports busy  output  1 and done  output  1, meaning sweep in progress and sweep completed, respectively.
REQ-013 The block SHALL have port ones_count  output  N_IN+1  meaning number of rows with out_bit=1 in the current/last sweep.

Function
REQ-014 The FSM SHALL have states IDLE, SWEEP and DONE; busy=1 only in SWEEP, done=1 only in DONE.
REQ-015 A start sampled high in IDLE or DONE SHALL move to SWEEP, clear ones_count and index, and clear done on the next edge.
REQ-016 In SWEEP, each cycle SHALL present exactly one row: in_vec=index, out_bit=lut[index], out_valid=1, all registered together; the first row appears one cycle after start is sampled.
REQ-017 The index SHALL increment by 1 per SWEEP cycle from 0 to 2^N_IN-1 with no skips or repeats; a full sweep lasts exactly 2^N_IN cycles.
REQ-018 ones_count SHALL increment in the same cycle as each presented row with out_bit=1; it SHALL never wrap, with a maximum of 2^N_IN.
REQ-019 After the row 2^N_IN-1 is presented, the next edge SHALL enter DONE with out_valid=0 and done=1; done and ones_count SHALL hold until the next start or reset.
REQ-020 In IDLE and DONE, out_valid SHALL be 0; in_vec and out_bit SHALL hold their last values.
REQ-021 lut_load SHALL be honoured only in IDLE or DONE; in SWEEP it SHALL be ignored so the table is stable for a whole sweep.
REQ-022 If lut_load and start are both high in IDLE/DONE, the table SHALL be loaded and start ignored in that cycle.
REQ-023 start SHALL be ignored in SWEEP.
REQ-024 abort sampled in SWEEP SHALL move to IDLE on the next edge: out_valid=0, done=0, and ones_count holding its partial value.
REQ-025 abort SHALL be ignored outside SWEEP.
REQ-026 If abort and start are both high, abort SHALL take precedence in SWEEP, and start SHALL be accepted in IDLE/DONE.

Reset
REQ-027 reset SHALL take precedence over all inputs.
REQ-028 On reset, the state SHALL be IDLE, lut = RESET_LUT, in_vec=0, out_bit=0, out_valid=0, busy=0, done=0 and ones_count=0.
REQ-029 reset asserted mid-sweep SHALL abandon the sweep with the same values as REQ-028 on the next edge.

Structure
REQ-030 The FSM state encoding and a rows-per-sweep constant function (2^N_IN) SHALL live in a shared package, lut_sweeper_pkg.
REQ-031 One sub-module, lut_eval (combinational table lookup: lut, index -> bit), SHALL be used.
REQ-032 All other logic SHALL be in lut_sweeper.

Verification
REQ-033 Reset, then start with N_IN=3 and the default table -> out_valid for 8 cycles, with rows 000..111 giving out_bit 0,1,0,0,0,1,1,1 and ones_count=4 with done=1 one cycle after the last row.
REQ-034 Load 8'hFF, then start -> all out_bit=1 and ones_count=8; load 8'h00, then start -> ones_count=0 and done=1.
REQ-035 Assert lut_load with 8'h00 in the third SWEEP cycle of a default-table sweep -> the sweep still yields ones_count=4.
REQ-036 Assert abort while row 011 is presented -> IDLE on the next edge, with out_valid=0, done=0 and ones_count=1.
REQ-037 Assert reset during row 101 -> on the next edge all outputs are 0 and lut=8'hE2, and a subsequent start produces the full default sweep.
REQ-038 Run with N_IN=1 and lut 2'b10 -> 2 rows with out_bit 0,1 and ones_count=1; run with N_IN=6 and an all-ones table -> 64 rows and ones_count=64 with no wrap.
